// File: rtl/gridx_tensor_pkg.sv
// Shared types and constants for the tensor MAC arbitration slice.
// The tensor unit computes D = A*B + C on 4x4 tiles (INT16 in, INT32 out).
package gridx_tensor_pkg;

    localparam int TU_A_W         = 256;
    localparam int TU_C_W         = 512;
    localparam int TU_ELEM_A_W    = 16;
    localparam int TU_ELEM_D_W    = 32;
    localparam int TU_NOMINAL_LAT = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } tarb_state_t;

endpackage

// File: rtl/tensor_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Shared by arbiters that front a single-issue functional unit.
module tensor_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] grant
);

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any   = 1'b0;
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                any   = 1'b1;
                grant = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/tensor_arbiter.sv
// Round-robin arbiter sharing one 4x4 tensor MAC unit between NUM_REQ requesters,
// with a single transaction in flight and a watchdog for a missing done pulse.
module tensor_arbiter
    import gridx_tensor_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TU_A_W-1:0] req_a,
    input  logic [NUM_REQ*TU_A_W-1:0] req_b,
    input  logic [NUM_REQ*TU_C_W-1:0] req_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [TU_C_W-1:0]         rsp_d,
    output logic                      rsp_err,
    output logic                      tu_start,
    input  logic                      tu_busy,
    input  logic                      tu_done,
    output logic [TU_A_W-1:0]         tu_a,
    output logic [TU_A_W-1:0]         tu_b,
    output logic [TU_C_W-1:0]         tu_c,
    input  logic [TU_C_W-1:0]         tu_d,
    output logic [7:0]                timeout_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    tarb_state_t       state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   grant_id_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic              rsp_valid_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [TU_C_W-1:0] rsp_d_reg;
    logic              rsp_err_reg;
    logic [7:0]        timeout_cnt_reg;

    logic              pick_any;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   rr_ptr_next;
    logic              issue_fire;

    tensor_rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .any   (pick_any),
        .grant (pick_id)
    );

    assign rr_ptr_next = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;

    // Start and consume happen in the same cycle the unit is seen idle.
    assign issue_fire = (state_reg == ISSUE) && !tu_busy;
    assign tu_start   = issue_fire;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = issue_fire && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    assign tu_a = req_a[int'(grant_id_reg) * TU_A_W +: TU_A_W];
    assign tu_b = req_b[int'(grant_id_reg) * TU_A_W +: TU_A_W];
    assign tu_c = req_c[int'(grant_id_reg) * TU_C_W +: TU_C_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            wdog_reg        <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_d_reg       <= '0;
            rsp_err_reg     <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        grant_id_reg <= pick_id;
                        rr_ptr_reg   <= rr_ptr_next;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!tu_busy) begin
                        wdog_reg  <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    // A real result wins over a watchdog expiry in the same cycle.
                    if (tu_done) begin
                        rsp_d_reg     <= tu_d;
                        rsp_err_reg   <= 1'b0;
                        rsp_id_reg    <= grant_id_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                        rsp_d_reg     <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_id_reg    <= grant_id_reg;
                        rsp_valid_reg <= 1'b1;
                        if (timeout_cnt_reg != 8'hFF) begin
                            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                        end
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_d       = rsp_d_reg;
    assign rsp_err     = rsp_err_reg;
    assign timeout_cnt = timeout_cnt_reg;

endmodule

// File: tb/tb_tensor_arbiter.sv
// Directed self-checking bench for tensor_arbiter with a behavioural tensor unit
// that pulses done TU_NOMINAL_LAT cycles after start (or never, when silenced).
module tb_tensor_arbiter;
    import gridx_tensor_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TU_A_W-1:0] req_a;
    logic [NUM_REQ*TU_A_W-1:0] req_b;
    logic [NUM_REQ*TU_C_W-1:0] req_c;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [TU_C_W-1:0]         rsp_d;
    logic                      rsp_err;
    logic                      tu_start;
    logic                      tu_busy;
    logic                      tu_done;
    logic [TU_A_W-1:0]         tu_a;
    logic [TU_A_W-1:0]         tu_b;
    logic [TU_C_W-1:0]         tu_c;
    logic [TU_C_W-1:0]         tu_d;
    logic [7:0]                timeout_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic              model_silent = 1'b0;
    logic              model_done   = 1'b0;
    logic [TU_C_W-1:0] model_d      = '0;
    logic [TU_C_W-1:0] d_pend       = '0;
    logic              pend         = 1'b0;
    int                cd           = 0;
    logic              late_done    = 1'b0;
    logic [TU_C_W-1:0] late_d       = '0;

    assign tu_done = model_done | late_done;
    assign tu_d    = late_done ? late_d : model_d;

    tensor_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_d       (rsp_d),
        .rsp_err     (rsp_err),
        .tu_start    (tu_start),
        .tu_busy     (tu_busy),
        .tu_done     (tu_done),
        .tu_a        (tu_a),
        .tu_b        (tu_b),
        .tu_c        (tu_c),
        .tu_d        (tu_d),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [TU_A_W-1:0] fill16(input int v);
        logic [TU_A_W-1:0] f;
        for (int i = 0; i < 16; i++) f[i*16 +: 16] = 16'(v);
        return f;
    endfunction

    function automatic logic [TU_C_W-1:0] fill32(input int v);
        logic [TU_C_W-1:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = 32'(v);
        return f;
    endfunction

    function automatic logic [TU_A_W-1:0] ident16();
        logic [TU_A_W-1:0] f;
        f = '0;
        for (int i = 0; i < 4; i++) f[(i*4+i)*16 +: 16] = 16'd1;
        return f;
    endfunction

    function automatic logic [TU_C_W-1:0] mac(input logic [TU_A_W-1:0] a,
                                               input logic [TU_A_W-1:0] b,
                                               input logic [TU_C_W-1:0] c);
        logic [TU_C_W-1:0] d;
        int acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = $signed(c[(i*4+j)*32 +: 32]);
                for (int k = 0; k < 4; k++)
                    acc += $signed(a[(i*4+k)*16 +: 16]) * $signed(b[(k*4+j)*16 +: 16]);
                d[(i*4+j)*32 +: 32] = acc;
            end
        end
        return d;
    endfunction

    // Tensor unit model: done pulses TU_NOMINAL_LAT cycles after the start cycle.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
            cd   <= 0;
        end else if (pend) begin
            if (cd == 1) begin
                model_done <= 1'b1;
                model_d    <= d_pend;
                pend       <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
        if (!reset && tu_start && !model_silent) begin
            pend   <= 1'b1;
            cd     <= TU_NOMINAL_LAT - 1;
            d_pend <= mac(tu_a, tu_b, tu_c);
        end
    end

    // Requester protocol: the granted request must stay asserted while in ISSUE.
    always @(posedge clk) begin
        if (!reset && dut.state_reg == ISSUE)
            assert (req_valid[dut.grant_id_reg] === 1'b1)
                else $error("protocol: requester %0d dropped req_valid in ISSUE", dut.grant_id_reg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [TU_C_W-1:0] obs, input logic [TU_C_W-1:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // which: 0 = tu_start, 1 = rsp_valid; an expired budget is a failed check.
    task automatic wait_for(input string tag, input int which, input int budget);
        int n;
        n = 0;
        while (((which == 0) ? tu_start : rsp_valid) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, TU_C_W'((which == 0) ? tu_start : rsp_valid), TU_C_W'(1));
    endtask

    initial begin
        int s;
        int last;
        int exp_id;

        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tu_busy   = 1'b0;
        // Requester r: A = identity, B = all (r+2), C = all (r+1) -> D = all (2r+3).
        for (int r = 0; r < NUM_REQ; r++) begin
            req_a[r*TU_A_W +: TU_A_W] = ident16();
            req_b[r*TU_A_W +: TU_A_W] = fill16(r + 2);
            req_c[r*TU_C_W +: TU_C_W] = fill32(r + 1);
        end
        tick();
        tick();
        tick();

        chk("rst_rsp_valid", TU_C_W'(rsp_valid), '0);
        chk("rst_req_ready", TU_C_W'(req_ready), '0);
        chk("rst_tu_start", TU_C_W'(tu_start), '0);
        chk("rst_rsp_err", TU_C_W'(rsp_err), '0);
        chk("rst_rsp_id", TU_C_W'(rsp_id), '0);
        chk("rst_rsp_d", rsp_d, '0);
        chk("rst_timeout_cnt", TU_C_W'(timeout_cnt), '0);
        chk("rst_tu_b", TU_C_W'(tu_b), TU_C_W'(fill16(2)));

        // Single request from requester 0 with exact latency.
        reset     = 1'b0;
        req_valid = 4'b0001;
        tick();
        chk("t1_start_c1", TU_C_W'(tu_start), TU_C_W'(1));
        chk("t1_ready_c1", TU_C_W'(req_ready), TU_C_W'(4'b0001));
        chk("t1_tu_a", TU_C_W'(tu_a), TU_C_W'(ident16()));
        tick();
        req_valid = '0;
        for (int i = 3; i <= 7; i++) tick();
        chk("t1_no_rsp_c7", TU_C_W'(rsp_valid), '0);
        tick();
        chk("t1_rsp_valid_c8", TU_C_W'(rsp_valid), TU_C_W'(1));
        chk("t1_rsp_id", TU_C_W'(rsp_id), '0);
        chk("t1_rsp_d", rsp_d, fill32(3));
        chk("t1_rsp_err", TU_C_W'(rsp_err), '0);
        rsp_ready = 1'b1;
        tick();
        chk("t1_rsp_drop_c9", TU_C_W'(rsp_valid), '0);

        // All four requesting continuously; grants 0,1,2,3,0 spaced 9 cycles.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 4'b1111;
        last      = 0;
        for (int n = 0; n < 5; n++) begin
            exp_id = n % 4;
            tick();
            wait_for("t2_start", 0, 40);
            chk("t2_grant", TU_C_W'(req_ready), TU_C_W'(1 << exp_id));
            if (n > 0) chk("t2_spacing", TU_C_W'(cyc - last), TU_C_W'(9));
            last = cyc;
            tick();
            wait_for("t2_rsp", 1, 40);
            chk("t2_rsp_id", TU_C_W'(rsp_id), TU_C_W'(exp_id));
            chk("t2_rsp_d", rsp_d, fill32(2 * exp_id + 3));
            if (n == 4) req_valid = 4'b0010;
        end

        // Pointer fairness: serve 1 (ptr -> 2), then 4'b0011 grants 0 before 1.
        tick();
        wait_for("t3_start1", 0, 20);
        chk("t3_grant1", TU_C_W'(req_ready), TU_C_W'(4'b0010));
        tick();
        wait_for("t3_rsp1", 1, 40);
        chk("t3_rsp_id1", TU_C_W'(rsp_id), TU_C_W'(1));
        req_valid = 4'b0011;
        tick();
        wait_for("t3_start0", 0, 20);
        chk("t3_grant0", TU_C_W'(req_ready), TU_C_W'(4'b0001));
        tick();
        wait_for("t3_rsp0", 1, 40);
        chk("t3_rsp_id0", TU_C_W'(rsp_id), '0);
        tick();
        wait_for("t3_start1b", 0, 20);
        chk("t3_grant1b", TU_C_W'(req_ready), TU_C_W'(4'b0010));
        rsp_ready = 1'b0;

        // Backpressure with a pending request from 2; no grant may issue from RESP.
        tick();
        req_valid    = 4'b0100;
        model_silent = 1'b1;
        wait_for("t4_rsp", 1, 40);
        chk("t4_rsp_id", TU_C_W'(rsp_id), TU_C_W'(1));
        chk("t4_rsp_d0", rsp_d, fill32(5));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold_valid", TU_C_W'(rsp_valid), TU_C_W'(1));
            chk("t4_hold_d", rsp_d, fill32(5));
            chk("t4_no_start", TU_C_W'(tu_start), '0);
        end
        tick();
        chk("t4_valid_c6", TU_C_W'(rsp_valid), TU_C_W'(1));
        rsp_ready = 1'b1;
        tick();
        chk("t4_idle_next", TU_C_W'(rsp_valid), '0);
        rsp_ready = 1'b0;

        // Timeout on requester 2: RESP exactly TIMEOUT cycles after entering WAIT.
        tick();
        wait_for("t5_start", 0, 20);
        chk("t5_grant", TU_C_W'(req_ready), TU_C_W'(4'b0100));
        s = cyc;
        tick();
        req_valid = '0;
        wait_for("t5_rsp", 1, 60);
        chk("t5_latency", TU_C_W'(cyc - s), TU_C_W'(TIMEOUT + 1));
        chk("t5_rsp_err", TU_C_W'(rsp_err), TU_C_W'(1));
        chk("t5_rsp_d", rsp_d, '0);
        chk("t5_rsp_id", TU_C_W'(rsp_id), TU_C_W'(2));
        chk("t5_timeout_cnt", TU_C_W'(timeout_cnt), TU_C_W'(1));
        late_done = 1'b1;
        late_d    = fill32(7);
        tick();
        late_done = 1'b0;
        chk("t5_late_d", rsp_d, '0);
        chk("t5_late_err", TU_C_W'(rsp_err), TU_C_W'(1));
        rsp_ready = 1'b1;
        tick();
        chk("t5_idle", TU_C_W'(rsp_valid), '0);
        late_done = 1'b1;
        tick();
        late_done = 1'b0;
        chk("t5_late_idle_valid", TU_C_W'(rsp_valid), '0);
        chk("t5_late_idle_d", rsp_d, '0);
        model_silent = 1'b0;

        // Busy stall: start delayed 3 cycles, then reset during WAIT.
        tu_busy   = 1'b1;
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stall_start", TU_C_W'(tu_start), '0);
            chk("t6_stall_ready", TU_C_W'(req_ready), '0);
        end
        tick();
        tu_busy = 1'b0;
        #1;
        chk("t6_start_late", TU_C_W'(tu_start), TU_C_W'(1));
        chk("t6_grant", TU_C_W'(req_ready), TU_C_W'(4'b0010));
        chk("t6_tu_b", TU_C_W'(tu_b), TU_C_W'(fill16(3)));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("t6_rst_valid", TU_C_W'(rsp_valid), '0);
        chk("t6_rst_err", TU_C_W'(rsp_err), '0);
        chk("t6_rst_id", TU_C_W'(rsp_id), '0);
        chk("t6_rst_cnt", TU_C_W'(timeout_cnt), '0);
        chk("t6_rst_start", TU_C_W'(tu_start), '0);
        chk("t6_rst_tu_b", TU_C_W'(tu_b), TU_C_W'(fill16(2)));
        reset     = 1'b0;
        req_valid = 4'b0110;
        tick();
        wait_for("t6_start2", 0, 20);
        chk("t6_ptr_zero", TU_C_W'(req_ready), TU_C_W'(4'b0010));
        s = cyc;
        tick();
        req_valid = '0;
        wait_for("t6_rsp", 1, 40);
        chk("t6_rsp_lat", TU_C_W'(cyc - s), TU_C_W'(TU_NOMINAL_LAT + 1));
        chk("t6_rsp_id", TU_C_W'(rsp_id), TU_C_W'(1));
        chk("t6_rsp_d", rsp_d, fill32(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
